program_loader: RTL

- Upstream neighbour of pipeline_processor: receives a framed program byte stream over a valid/ready byte interface and writes it into the processor's 16-entry instruction/data memory.
- After a frame passes its checksum, pulses the processor restart and raises controller_enable to start execution.
- Sits between the host/serial front end and the pipeline_processor memory write port and control inputs.

---
 rtl/program_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Framed program loader: length/data/checksum byte stream into processor memory, then restart and run.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              main_clk,
  input  logic              restart_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              proc_restart,
  output logic              controller_enable,
  input  logic              reload,
  input  logic              err_clr,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LENGTH  = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  if (DEPTH > (32'd1 << ADDR_W) || TIMEOUT_CYC == 0) begin : g_cfg_chk
    $error("program_loader: DEPTH exceeds address space or TIMEOUT_CYC is zero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CSUM,
    S_START,
    S_RUN,
    S_ERR
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [DATA_W-1:0]  r_sum, w_sum_nxt;
  logic [1:0]         r_err_code, w_err_code_nxt;

  logic               r_rx_ready;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_proc_restart;
  logic               r_ctrl_en;
  logic               r_load_busy;
  logic               r_load_done;
  logic               r_load_err;

  logic               w_xfer;
  logic               w_wr;

  assign w_xfer = rx_valid & r_rx_ready;
  assign w_wr   = (r_state == S_DATA) && w_xfer;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_hit;

  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYC));

  // Idle-cycle counter, restarted on every accepted byte and every state change
  always_ff @(posedge main_clk or negedge restart_n) begin
    if (!restart_n) begin
      r_tmo <= '0;
    end else if (w_xfer || (w_state_nxt != r_state) ||
                 !((r_state == S_DATA) || (r_state == S_CSUM))) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`endif

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_sum_nxt      = r_sum;
    w_err_code_nxt = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if ((rx_data == '0) || (rx_data > DATA_W'(DEPTH))) begin
            w_state_nxt    = S_ERR;
            w_err_code_nxt = ERR_LENGTH;
          end else begin
            w_cnt_nxt   = CNT_W'(rx_data);
            w_addr_nxt  = '0;
            w_sum_nxt   = rx_data;
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_sum_nxt  = r_sum + rx_data;
          w_addr_nxt = r_addr + ADDR_W'(1);
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_CSUM;
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_state_nxt    = S_ERR;
          w_err_code_nxt = ERR_TIMEOUT;
        end
`endif
      end
      S_CSUM: begin
        if (w_xfer) begin
          if (rx_data == r_sum) begin
            w_state_nxt = S_START;
          end else begin
            w_state_nxt    = S_ERR;
            w_err_code_nxt = ERR_CSUM;
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_state_nxt    = S_ERR;
          w_err_code_nxt = ERR_TIMEOUT;
        end
`endif
      end
      S_START: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (reload) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          w_state_nxt    = S_IDLE;
          w_err_code_nxt = ERR_NONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge main_clk or negedge restart_n) begin
    if (!restart_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_sum      <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_sum      <= w_sum_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with r_state
  always_ff @(posedge main_clk or negedge restart_n) begin
    if (!restart_n) begin
      r_rx_ready     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_proc_restart <= 1'b0;
      r_ctrl_en      <= 1'b0;
      r_load_busy    <= 1'b0;
      r_load_done    <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_rx_ready     <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DATA) ||
                        (w_state_nxt == S_CSUM);
      r_mem_we       <= w_wr;
      if (w_wr) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= rx_data;
      end
      r_proc_restart <= (w_state_nxt == S_START);
      r_ctrl_en      <= (w_state_nxt == S_RUN);
      r_load_done    <= (w_state_nxt == S_RUN);
      r_load_busy    <= (w_state_nxt == S_DATA) || (w_state_nxt == S_CSUM) ||
                        (w_state_nxt == S_START);
      r_load_err     <= (w_state_nxt == S_ERR);
    end
  end

  assign rx_ready          = r_rx_ready;
  assign mem_we            = r_mem_we;
  assign mem_addr          = r_mem_addr;
  assign mem_wdata         = r_mem_wdata;
  assign proc_restart      = r_proc_restart;
  assign controller_enable = r_ctrl_en;
  assign load_busy         = r_load_busy;
  assign load_done         = r_load_done;
  assign load_err          = r_load_err;
  assign err_code          = r_err_code;

endmodule
